reg_dump_reader: RTL and testbench

Debug-side reader for `register_bank`. On a `start` pulse it walks every register address 0 to 2**REG_ADDR_BITS-1 through read port A and captures each word. It streams each word as bytes, MSB first, over a valid/ready byte interface to the debug UART transmitter. It sits between the register bank's port A mux and the debug unit, and is active only while the pipeline is halted for a dump.

---
 rtl/reg_dump_pkg.sv | 25 ++
 rtl/word_byte_serializer.sv | 56 +++++
 rtl/reg_dump_reader.sv | 112 +++++++++++
 tb/tb_reg_dump_reader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
// Shared types and helpers for the register dump reader.
//   state_t      : dump FSM states
//   calc_nb      : bytes per register word
//   calc_cnt_w   : width of the byte counter (at least 1 bit)
package reg_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    function automatic int calc_nb(input int reg_width);
        return reg_width / 8;
    endfunction

    function automatic int calc_cnt_w(input int reg_width);
        int nb;
        nb = reg_width / 8;
        return (nb <= 1) ? 1 : $clog2(nb);
    endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// Parallel-load shift register that emits a word MSB byte first over a
// valid/ready byte interface.
//   clk, reset     : clock, synchronous active-high reset
//   i_load         : load i_word and start emitting its bytes
//   i_word         : word to serialize
//   o_byte_data    : current byte (top byte of the shift register)
//   o_byte_valid   : byte is valid, held until accepted
//   i_byte_ready   : sink accepts the byte
//   o_last         : strobe, the final byte of the word is being accepted
module word_byte_serializer
    import reg_dump_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic [REG_WIDTH-1:0] i_word,
    output logic [7:0]           o_byte_data,
    output logic                 o_byte_valid,
    input  logic                 i_byte_ready,
    output logic                 o_last
);

    localparam int NB    = calc_nb(REG_WIDTH);
    localparam int CNT_W = calc_cnt_w(REG_WIDTH);

    logic [REG_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_valid;
    logic                 w_hs;

    assign w_hs         = r_valid & i_byte_ready;
    assign o_last       = w_hs && (r_cnt == CNT_W'(NB - 1));
    assign o_byte_data  = r_shift[REG_WIDTH-1 -: 8];
    assign o_byte_valid = r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_word;
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (w_hs) begin
            r_shift <= r_shift << 8;
            r_cnt   <= r_cnt + 1'b1;
            // valid drops only on the final handshake, never while stalled
            if (o_last)
                r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_dump_reader.sv
// Debug-side reader: walks every register address through the bank's read
// port A, captures each word and streams it MSB byte first to the debug UART.
//   clk, reset    : clock, synchronous active-high reset
//   start         : dump request, only honoured in IDLE
//   write_w_mon   : bank write strobe; read data is frozen while high
//   addr_reg_rd   : read address to the bank
//   reg_data_in   : bank read data (one cycle after the address)
//   byte_data/byte_valid/byte_ready : outgoing byte stream
//   busy          : dump in progress (through the DONE cycle)
//   done          : one-cycle pulse after the last byte is accepted
//
// state   | meaning
// IDLE    | waiting for start, address holds its last value
// ISSUE   | address on the bank, wait for a cycle with no bank write
// CAPTURE | bank read data valid, load it into the serializer
// SEND    | stream the word's bytes; advance address after the last one
// DONE    | done pulse, return to IDLE
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int REG_WIDTH     = 32,
    parameter int REG_ADDR_BITS = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     write_w_mon,
    output logic [REG_ADDR_BITS-1:0] addr_reg_rd,
    input  logic [REG_WIDTH-1:0]     reg_data_in,
    output logic [7:0]               byte_data,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic                     busy,
    output logic                     done
);

    if (REG_WIDTH % 8 != 0) begin : g_bad_width
        $error("reg_dump_reader: REG_WIDTH must be a multiple of 8");
    end

    state_t                   r_state;
    logic [REG_ADDR_BITS-1:0] r_addr;
    logic                     r_busy;
    logic                     r_done;
    logic                     w_load;
    logic                     w_last;

    assign w_load      = (r_state == CAPTURE);
    assign addr_reg_rd = r_addr;
    assign busy        = r_busy;
    assign done        = r_done;

    word_byte_serializer #(
        .REG_WIDTH (REG_WIDTH)
    ) u_ser (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_load),
        .i_word       (reg_data_in),
        .o_byte_data  (byte_data),
        .o_byte_valid (byte_valid),
        .i_byte_ready (byte_ready),
        .o_last       (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // the bank only latches the address on a non-write edge
                    if (!write_w_mon)
                        r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_state <= SEND;
                end
                SEND: begin
                    if (w_last) begin
                        if (&r_addr) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

    typedef struct {
        string name;
        bit    bp;
        bit    wstall;
        bit    repulse;
        int    exp_bytes;
        int    exp_first;
        int    exp_done;
    } scen_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main DUT (defaults)
    logic        reset, start, write_w_mon;
    logic [4:0]  addr_reg_rd;
    logic [31:0] reg_data_in;
    logic [7:0]  byte_data;
    logic        byte_valid, byte_ready, busy, done;

    // narrow DUT (REG_WIDTH=16, REG_ADDR_BITS=3)
    logic        s_reset, s_start, s_wr, s_ready;
    logic [2:0]  s_addr;
    logic [15:0] s_rd;
    logic [7:0]  s_bdata;
    logic        s_bvalid, s_busy, s_done;

    reg_dump_reader u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .write_w_mon (write_w_mon),
        .addr_reg_rd (addr_reg_rd),
        .reg_data_in (reg_data_in),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .busy        (busy),
        .done        (done)
    );

    reg_dump_reader #(.REG_WIDTH(16), .REG_ADDR_BITS(3)) u_dut16 (
        .clk         (clk),
        .reset       (s_reset),
        .start       (s_start),
        .write_w_mon (s_wr),
        .addr_reg_rd (s_addr),
        .reg_data_in (s_rd),
        .byte_data   (s_bdata),
        .byte_valid  (s_bvalid),
        .byte_ready  (s_ready),
        .busy        (s_busy),
        .done        (s_done)
    );

    // register bank models: one-cycle read latency, reads frozen during writes
    logic [31:0] bank [0:31];
    logic        preload;
    logic [31:0] wr_data;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) bank[i] <= 32'hA500_0000 | 32'(i);
        end else if (write_w_mon) begin
            bank[5] <= wr_data;
        end
        if (!write_w_mon) reg_data_in <= bank[addr_reg_rd];
    end

    always @(posedge clk) s_rd <= 16'hC300 | 16'(s_addr);

    // ready driver
    logic        bp_mode;
    logic [15:0] lfsr;
    initial begin
        lfsr       = 16'hACE1;
        byte_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                lfsr       = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                byte_ready = lfsr[0];
            end else begin
                byte_ready = 1'b1;
            end
        end
    end

    // byte monitor for the main DUT (sampled mid-cycle)
    logic [7:0] q [$];
    logic       mon_clr;
    int         first_valid, done_cnt, done_cyc, stall_cnt, stall_bad;
    logic       prev_stall;
    logic [7:0] prev_data;

    always @(negedge clk) begin
        if (mon_clr) begin
            q.delete();
            first_valid = -1;
            done_cnt    = 0;
            done_cyc    = -1;
            stall_cnt   = 0;
            stall_bad   = 0;
            prev_stall  = 1'b0;
        end else begin
            if (prev_stall && (!byte_valid || byte_data != prev_data)) stall_bad++;
            if (byte_valid && first_valid < 0) first_valid = cyc;
            if (byte_valid && byte_ready) q.push_back(byte_data);
            if (byte_valid && !byte_ready) stall_cnt++;
            prev_stall = byte_valid && !byte_ready;
            prev_data  = byte_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // byte monitor for the narrow DUT (ready tied high)
    logic [7:0] s_q [$];
    int         s_first = -1, s_done_cnt = 0, s_done_cyc = -1;
    always @(negedge clk) begin
        if (s_bvalid) s_q.push_back(s_bdata);
        if (s_bvalid && s_first < 0) s_first = cyc;
        if (s_done) begin
            s_done_cnt++;
            s_done_cyc = cyc;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic run_scen(input scen_t s);
        int          n, mism, r, b, exp_done;
        logic [31:0] w;
        logic [7:0]  eb;
        bit          seen_done;
        preload = 1'b1;
        mon_clr = 1'b1;
        bp_mode = s.bp;
        @(posedge clk); #1;
        preload = 1'b0;
        @(posedge clk); #1;
        mon_clr = 1'b0;
        start   = 1'b1;
        n       = cyc + 1;
        seen_done = 1'b0;
        for (int t = 0; t < 2000 && !seen_done; t++) begin
            @(posedge clk); #1;
            if (cyc == n) start = 1'b0;
            if (s.wstall) begin
                if (cyc == n + 30) write_w_mon = 1'b1;
                if (cyc >= n + 31 && cyc <= n + 33) begin
                    check({s.name, "_issue_addr"}, int'(addr_reg_rd), 5);
                    check({s.name, "_issue_novalid"}, int'(byte_valid), 0);
                end
                if (cyc == n + 33) write_w_mon = 1'b0;
            end
            if (s.repulse) begin
                if (cyc == n + 50 || cyc == n + 192) start = 1'b1;
                if (cyc == n + 51 || cyc == n + 193) start = 1'b0;
            end
            if (done_cnt > 0) seen_done = 1'b1;
        end
        start = 1'b0;
        write_w_mon = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        check({s.name, "_done_seen"}, int'(seen_done), 1);
        check({s.name, "_byte_count"}, q.size(), s.exp_bytes);
        mism = 0;
        foreach (q[j]) begin
            r  = j / 4;
            b  = j % 4;
            w  = (s.wstall && r == 5) ? 32'hDEAD_BEEF : (32'hA500_0000 | 32'(r));
            eb = 8'(w >> (8 * (3 - b)));
            if (q[j] != eb) mism++;
        end
        check({s.name, "_byte_mismatches"}, mism, 0);
        check({s.name, "_first_valid"}, first_valid - n, s.exp_first);
        exp_done = s.exp_done + (s.bp ? stall_cnt : 0);
        check({s.name, "_done_cycle"}, done_cyc - n, exp_done);
        check({s.name, "_done_pulses"}, done_cnt, 1);
        check({s.name, "_idle_busy"}, int'(busy), 0);
        check({s.name, "_stall_stable"}, stall_bad, 0);
    endtask

    scen_t tbl [4];

    initial begin
        int n, bad, mism;
        reset = 1'b1; start = 1'b0; write_w_mon = 1'b0;
        s_reset = 1'b1; s_start = 1'b0; s_wr = 1'b0; s_ready = 1'b1;
        bp_mode = 1'b0; mon_clr = 1'b1; preload = 1'b0; wr_data = 32'hDEAD_BEEF;

        tbl[0] = '{"base",    1'b0, 1'b0, 1'b0, 128, 2, 192};
        tbl[1] = '{"backpr",  1'b1, 1'b0, 1'b0, 128, 2, 192};
        tbl[2] = '{"wstall",  1'b0, 1'b1, 1'b0, 128, 2, 195};
        tbl[3] = '{"repulse", 1'b0, 1'b0, 1'b1, 128, 2, 192};

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(byte_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_addr", int'(addr_reg_rd), 0);
        check("rst_data", int'(byte_data), 0);
        reset = 1'b0;
        s_reset = 1'b0;

        for (int k = 0; k < 4; k++) run_scen(tbl[k]);

        // reset during SEND of reg 10, byte 2
        bp_mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        n = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 200 && cyc < n + 64; t++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_addr", int'(addr_reg_rd), 10);
        check("pre_rst_valid", int'(byte_valid), 1);
        check("pre_rst_byte", int'(byte_data), 8'h00);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("post_rst_valid", int'(byte_valid), 0);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_addr", int'(addr_reg_rd), 0);
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (byte_valid || busy || done) bad++;
        end
        check("post_rst_quiet", bad, 0);
        run_scen(tbl[0]);

        // narrow configuration
        @(posedge clk); #1;
        s_start = 1'b1;
        n = cyc + 1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int t = 0; t < 500 && s_done_cnt == 0; t++) begin
            @(posedge clk); #1;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("w16_byte_count", s_q.size(), 16);
        mism = 0;
        foreach (s_q[j]) begin
            if (s_q[j] != ((j % 2 == 0) ? 8'hC3 : 8'(j / 2))) mism++;
        end
        check("w16_byte_mismatches", mism, 0);
        check("w16_first_valid", s_first - n, 2);
        check("w16_done_cycle", s_done_cyc - n, 32);
        check("w16_done_pulses", s_done_cnt, 1);
        check("w16_idle_busy", int'(s_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
